// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter: FSM state
// encoding, default bus widths and requester port indices.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned ADDR_W_DEF = 18;
  localparam int unsigned DATA_W_DEF = 32;

  // Port 0 is the memory stage, port 1 the secondary master.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Wide enough for the largest legal TIMEOUT (255).
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/sram_arb_grant.sv
// Combinational two-requester grant selector. With SRAM_ARB_RR_EN defined a
// conflict goes to the port named by ptr_i; otherwise port 0 always wins.
module sram_arb_grant
  import sram_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,
  output logic valid_o,
  output logic gnt_o
);

  assign valid_o = req0_i | req1_i;

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    if (req0_i && req1_i) gnt_o = ptr_i;
    else                  gnt_o = req1_i ? PORT1 : PORT0;
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr_i;
  assign gnt_o      = (req1_i && !req0_i) ? PORT1 : PORT0;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single SRAM controller, one transaction at a
// time with a BUSY timeout. Define SRAM_ARB_RR_EN for round-robin conflicts.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_re,
  input  logic              p0_we,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ack,
  output logic              p0_err,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_re,
  input  logic              p1_we,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re_en,
  output logic              mem_we_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              rr_ptr, gnt_valid, gnt_sel;

  sram_arb_grant u_grant (
    .req0_i  (p0_re | p0_we),
    .req1_i  (p1_re | p1_we),
    .ptr_i   (rr_ptr),
    .valid_o (gnt_valid),
    .gnt_o   (gnt_sel)
  );

`ifdef SRAM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // After every completion the port that was not just served gets priority.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == DONE) ptr_d = ~gnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= PORT0;
    else     ptr_q <= ptr_d;
  end

  assign rr_ptr = ptr_q;
`else
  assign rr_ptr = PORT0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= PORT0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      // NOTE: datapath registers are reset too because they drive ports that must read zero.
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    // NOTE: every _d defaults to its hold value first, so no branch can infer a latch.
    state_d  = state_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = BUSY;
          gnt_d   = gnt_sel;
          we_d    = gnt_sel ? p1_we : p0_we;
          addr_d  = gnt_sel ? p1_addr : p0_addr;
          wdata_d = gnt_sel ? p1_wdata : p0_wdata;
          err_d   = 1'b0;
          cnt_d   = CNT_W'(1);
        end
      end
      BUSY: begin
        // mem_ready is only honoured from the second BUSY cycle onward.
        if (mem_ready && cnt_q >= CNT_W'(2)) begin
          state_d = DONE;
          if (!we_q) begin
            if (gnt_q == PORT1) rdata1_d = mem_rdata;
            else                rdata0_d = mem_rdata;
          end
        end else if (cnt_q >= TIMEOUT_C) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    mem_re_en = (state_q == BUSY) && !we_q;
    mem_we_en = (state_q == BUSY) && we_q;
    p0_ack    = (state_q == DONE) && !err_q && (gnt_q == PORT0);
    p1_ack    = (state_q == DONE) && !err_q && (gnt_q == PORT1);
    p0_err    = (state_q == DONE) && err_q && (gnt_q == PORT0);
    p1_err    = (state_q == DONE) && err_q && (gnt_q == PORT1);
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, arbitration and
// reset sequences, then randomized transactions against a transaction model.
module tb_sram_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] p0_addr, p1_addr, mem_addr;
  logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_wdata, mem_rdata;
  logic        p0_re, p0_we, p1_re, p1_we;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic        mem_re_en, mem_we_en, mem_ready, busy;

  sram_arbiter #(.ADDR_W(18), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_re(p0_re), .p0_we(p0_we),
    .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_err(p0_err),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_re(p1_re), .p1_we(p1_we),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re_en(mem_re_en),
    .mem_we_en(mem_we_en), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester-side state and reference model.
  bit          b_re[2];
  bit          b_we[2];
  logic [17:0] b_addr[2];
  logic [31:0] b_wdata[2];
  logic [31:0] exp_rdata[2];
  int          pref;

  typedef struct {
    int          port;
    bit          re;
    bit          we;
    logic [17:0] addr;
    logic [31:0] wdata;
    int          ready_from;
    logic [31:0] rdata;
    int          drop_at;
    int          exp_len;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    p0_re = b_re[0]; p0_we = b_we[0]; p0_addr = b_addr[0]; p0_wdata = b_wdata[0];
    p1_re = b_re[1]; p1_we = b_we[1]; p1_addr = b_addr[1]; p1_wdata = b_wdata[1];
  endtask

  function automatic logic ack_of(input int p);
    return (p == 1) ? p1_ack : p0_ack;
  endfunction

  function automatic logic err_of(input int p);
    return (p == 1) ? p1_err : p0_err;
  endfunction

  // Arbitration rule: a lone request wins; on conflict port 0 (fixed) or the
  // port not served last (round-robin, starting with port 0).
  function automatic int pick();
    bit q0, q1;
    q0 = b_re[0] | b_we[0];
    q1 = b_re[1] | b_we[1];
    if (q0 && q1) begin
`ifdef SRAM_ARB_RR_EN
      return pref;
`else
      return 0;
`endif
    end
    return q1 ? 1 : 0;
  endfunction

  // mem_ready is held high from BUSY cycle ready_from on (0 = never).
  function automatic bit times_out(input int ready_from);
    return (ready_from == 0) || (ready_from > TIMEOUT);
  endfunction

  function automatic int busy_len(input int ready_from);
    if (times_out(ready_from)) return TIMEOUT;
    return (ready_from < 2) ? 2 : ready_from;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      b_re[p] = 1'b0; b_we[p] = 1'b0; b_addr[p] = '0; b_wdata[p] = '0; exp_rdata[p] = '0;
    end
    apply();
    mem_ready = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    rst  = 1'b0;
    pref = 0;
  endtask

  // Entered in an IDLE cycle with requests driven; leaves in the next IDLE cycle.
  task automatic serve(input int w, input int exp_len, input bit exp_err, input int ready_from,
                       input logic [31:0] rd, input int drop_at, input bit hold);
    bit          is_we;
    int          o;
    logic [17:0] ea;
    logic [31:0] ew;
    is_we = b_we[w];
    o     = 1 - w;
    ea    = b_addr[w];
    ew    = b_wdata[w];
    check("idle_busy", busy, 1'b0);
    for (int k = 1; k <= exp_len; k++) begin
      tick();
      mem_ready = (ready_from != 0) && (k >= ready_from);
      mem_rdata = (k == exp_len) ? rd : ~rd;
      check("busy", busy, 1'b1);
      check("mem_we_en", mem_we_en, is_we);
      check("mem_re_en", mem_re_en, !is_we);
      check("mem_addr", mem_addr, ea);
      check("mem_wdata", mem_wdata, ew);
      check("early_ack", ack_of(w) | ack_of(o), 1'b0);
      check("early_err", err_of(w) | err_of(o), 1'b0);
      if (k == drop_at) begin
        b_re[w] = 1'b0; b_we[w] = 1'b0; apply();
      end
    end
    tick();
    mem_ready = 1'b0;
    if (!exp_err && !is_we) exp_rdata[w] = rd;
    check("done_busy", busy, 1'b1);
    check("done_en", {mem_re_en, mem_we_en}, 2'b00);
    check($sformatf("p%0d_ack", w), ack_of(w), !exp_err);
    check($sformatf("p%0d_err", w), err_of(w), exp_err);
    check($sformatf("p%0d_silent", o), {ack_of(o), err_of(o)}, 2'b00);
    check("p0_rdata", p0_rdata, exp_rdata[0]);
    check("p1_rdata", p1_rdata, exp_rdata[1]);
    pref = o;
    if (!hold) begin
      b_re[w] = 1'b0; b_we[w] = 1'b0;
    end
    apply();
    tick();
  endtask

  int w, rf, n0;
  bit h;

  initial begin
    vecs[0] = '{0, 1'b0, 1'b1, 18'h00010, 32'hDEADBEEF, 4,  32'h0,        0, 4,  1'b0};
    vecs[1] = '{1, 1'b1, 1'b0, 18'h3FFFF, 32'h0BADF00D, 3,  32'h12345678, 0, 3,  1'b0};
    vecs[2] = '{0, 1'b1, 1'b0, 18'h00001, 32'h11111111, 1,  32'hCAFEF00D, 0, 2,  1'b0};
    vecs[3] = '{0, 1'b1, 1'b0, 18'h00ABC, 32'h22222222, 0,  32'h55AA55AA, 0, 15, 1'b1};
    vecs[4] = '{1, 1'b1, 1'b0, 18'h12345, 32'h33333333, 15, 32'hA5A5A5A5, 0, 15, 1'b0};
    vecs[5] = '{1, 1'b1, 1'b0, 18'h2AAAA, 32'h44444444, 16, 32'h0F0F0F0F, 0, 15, 1'b1};
    vecs[6] = '{1, 1'b1, 1'b1, 18'h15555, 32'h87654321, 2,  32'hFFFF0000, 0, 2,  1'b0};
    vecs[7] = '{0, 1'b1, 1'b0, 18'h00777, 32'h66666666, 5,  32'h00C0FFEE, 2, 5,  1'b0};

    do_reset();
    check("rst_busy", busy, 1'b0);
    check("rst_en", {mem_re_en, mem_we_en}, 2'b00);
    check("rst_ack", {p0_ack, p1_ack}, 2'b00);
    check("rst_err", {p0_err, p1_err}, 2'b00);
    check("rst_p0_rdata", p0_rdata, 32'h0);
    check("rst_p1_rdata", p1_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 18'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);

    foreach (vecs[i]) begin
      b_re[vecs[i].port]    = vecs[i].re;
      b_we[vecs[i].port]    = vecs[i].we;
      b_addr[vecs[i].port]  = vecs[i].addr;
      b_wdata[vecs[i].port] = vecs[i].wdata;
      apply();
      serve(vecs[i].port, vecs[i].exp_len, vecs[i].exp_err, vecs[i].ready_from,
            vecs[i].rdata, vecs[i].drop_at, 1'b0);
    end

    // Simultaneous reads from both ports after a fresh reset.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      b_re[p] = 1'b1; b_addr[p] = 18'(p * 18'h100 + 18'h40); b_wdata[p] = 32'(p + 7);
    end
    apply();
    while (pick() >= 0 && (b_re[0] | b_re[1])) begin
      w = pick();
      serve(w, 3, 1'b0, 3, 32'hB0B00000 + 32'(w), 0, 1'b0);
    end

    // Port 0 keeps its request up through its first DONE while port 1 waits.
    for (int p = 0; p < 2; p++) begin
      b_we[p] = 1'b1; b_addr[p] = 18'(p + 18'h200); b_wdata[p] = 32'(32'hAB00 + p);
    end
    apply();
    n0 = 0;
    while (b_we[0] | b_we[1]) begin
      w  = pick();
      h  = (w == 0) && (n0 == 0);
      n0 = n0 + ((w == 0) ? 1 : 0);
      serve(w, 2, 1'b0, 2, 32'h0, 0, h);
    end

    // Reset during the third BUSY cycle aborts silently.
    b_re[0] = 1'b1; b_addr[0] = 18'h00155; b_wdata[0] = 32'h5;
    apply();
    tick(); tick(); tick();
    check("pre_abort_re_en", mem_re_en, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b_re[0] = 1'b0;
    apply();
    exp_rdata[0] = '0; exp_rdata[1] = '0; pref = 0;
    check("abort_en", {mem_re_en, mem_we_en}, 2'b00);
    check("abort_busy", busy, 1'b0);
    check("abort_ack_err", {p0_ack, p0_err, p1_ack, p1_err}, 4'b0000);
    check("abort_mem_addr", mem_addr, 18'h0);
    tick();
    check("abort_late", {busy, p0_ack, p0_err}, 3'b000);
    b_re[0] = 1'b1; b_addr[0] = 18'h00099;
    apply();
    serve(0, 3, 1'b0, 3, 32'h600DCAFE, 0, 1'b0);

    // Randomized traffic against the transaction model.
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < 2; p++) begin
        b_we[p] = 1'b0; b_re[p] = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 2))
            0:       b_re[p] = 1'b1;
            1:       b_we[p] = 1'b1;
            default: begin b_re[p] = 1'b1; b_we[p] = 1'b1; end
          endcase
        end
        b_addr[p]  = 18'($urandom);
        b_wdata[p] = $urandom;
      end
      if (!(b_re[0] | b_we[0] | b_re[1] | b_we[1])) b_re[$urandom_range(0, 1)] = 1'b1;
      apply();
      while (b_re[0] | b_we[0] | b_re[1] | b_we[1]) begin
        w  = pick();
        rf = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 2));
        serve(w, busy_len(rf), times_out(rf), rf, $urandom, 0, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, 18, SRAM word-address width.
REQ-002 Parameter DATA_W, 32, requester data width.
REQ-003 Parameter TIMEOUT, 15, max BUSY cycles before abort (4..255).
REQ-004 One clock; reset is synchronous and active-high; ports named clk and rst.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 pN_addr  in  ADDR_W  requester N address (N = 0 memory stage, N = 1 secondary master).
REQ-008 pN_wdata  in  DATA_W  requester N write data.
REQ-009 pN_re / pN_we  in  1  requester N read / write request, held until pN_ack or pN_err.
REQ-010 pN_rdata  out  DATA_W  registered read data, valid on pN_ack of a read.
REQ-011 pN_ack / pN_err  out  1  one-cycle completion / timeout pulse.
REQ-012 mem_addr, mem_wdata, mem_re_en, mem_we_en  out  ADDR_W/DATA_W/1/1  to SRAM controller.
REQ-013 mem_rdata  in  DATA_W; mem_ready  in  1  from SRAM controller.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, BUSY, DONE; IDLE->BUSY on any pending request, BUSY->DONE on mem_ready or timeout, DONE->IDLE unconditionally.
REQ-016 Grant decided in IDLE, registered on IDLE->BUSY edge; address, wdata and op latched at that edge and held constant through BUSY.
REQ-017 Single pending request -> granted; both pending -> per REQ-031/REQ-032.
REQ-018 pN_re and pN_we both high -> treated as write.
REQ-019 In BUSY only, exactly one of mem_re_en/mem_we_en high; both low in IDLE and DONE.
REQ-020 mem_ready is ignored in the first BUSY cycle; BUSY ends on first mem_ready=1 from the second BUSY cycle onward.
REQ-021 On BUSY exit via mem_ready for a read, mem_rdata captured into granted pN_rdata; non-granted pN_rdata unchanged.
REQ-022 pN_ack pulses in DONE for granted port only; latency request-to-ack = BUSY length + 2 cycles.
REQ-023 DONE guarantees at least one enable-low cycle between back-to-back transactions (controller counter clear).
REQ-024 BUSY cycle counter reaching TIMEOUT without mem_ready -> DONE with pN_err instead of pN_ack, rdata unchanged.
REQ-025 Requester deasserting request during BUSY -> transaction still completes, ack still issued.
REQ-026 Request held high through DONE is a new request in following IDLE.
REQ-027 mem_addr/mem_wdata outputs are latched values; zero when never granted.

Reset
REQ-028 rst -> state IDLE, grant 0, round-robin pointer 0, timeout counter 0.
REQ-029 rst -> all pN_ack, pN_err, mem_re_en, mem_we_en, busy = 0; pN_rdata, mem_addr, mem_wdata = 0.
REQ-030 rst asserted mid-BUSY -> enables low next edge, no ack/err issued for aborted transaction.

Configuration
REQ-031 Macro SRAM_ARB_RR_EN defined -> round-robin: on conflict, port other than last-served wins; pointer updates on each DONE.
REQ-032 SRAM_ARB_RR_EN undefined -> fixed priority, port 0 always wins conflicts; no pointer register.

Structure
REQ-033 Package sram_arb_pkg holds state enum (IDLE, BUSY, DONE), default ADDR_W/DATA_W, port index constants.
REQ-034 One sub-module sram_arb_grant: combinational two-input grant selector, pointer input, honours SRAM_ARB_RR_EN.

Verification
REQ-035 p0 write addr 0x00010 data 0xDEADBEEF, mem_ready after 4 BUSY cycles -> mem_we_en high 4 cycles, p0_ack at cycle 6, p1 silent.
REQ-036 p0 and p1 read same cycle, RR enabled -> p0 served, then p1; RR disabled, p0 held high -> p0 served twice before p1.
REQ-037 p1 read, mem_rdata 0x12345678 at mem_ready -> p1_rdata 0x12345678 on p1_ack, p0_rdata unchanged.
REQ-038 mem_ready held low, TIMEOUT=15 -> p0_err pulse after 15 BUSY cycles, no ack, FSM back to IDLE.
REQ-039 rst pulse in third BUSY cycle -> enables low, busy 0, no ack/err, next request served normally.
